// File: rtl/fetch_mem_arbiter.sv
// Single-port memory arbiter between the fetch and memory stages: data wins,
// fetch starvation is bounded, and an in-flight fetch can be discarded on redirect.
module fetch_mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              f_req,
   input  logic [AW-1:0]     f_addr,
   input  logic              f_flush,
   output logic [DW-1:0]     f_rdata,
   output logic              f_valid,
   output logic              f_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [AW-1:0]     d_addr,
   input  logic [DW-1:0]     d_wdata,
   input  logic [DW/8-1:0]   d_be,
   output logic [DW-1:0]     d_rdata,
   output logic              d_valid,
   output logic              d_stall,
   output logic              m_req,
   output logic              m_we,
   output logic [AW-1:0]     m_addr,
   output logic [DW-1:0]     m_wdata,
   output logic [DW/8-1:0]   m_be,
   input  logic              m_ack,
   input  logic [DW-1:0]     m_rdata
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_TOP = CW'(STARVE_MAX);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_F = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             m_we_q, m_we_d;
   logic [AW-1:0]    m_addr_q, m_addr_d;
   logic [DW-1:0]    m_wdata_q, m_wdata_d;
   logic [DW/8-1:0]  m_be_q, m_be_d;
   logic [CW-1:0]    starve_q, starve_d;
   logic             discard_q, discard_d;
   logic             grant_d, grant_f;

   always_comb begin
      grant_d = 1'b0;
      grant_f = 1'b0;
      if (state_q == IDLE) begin
         if (d_req && !(f_req && (starve_q == STARVE_TOP))) begin
            grant_d = 1'b1;
         end else if (f_req) begin
            grant_f = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_be_d    = m_be_q;
      starve_d  = starve_q;
      discard_d = discard_q;
      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d   = BUSY_D;
               m_we_d    = d_we;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
               m_be_d    = d_be;
               if (f_req && (starve_q != STARVE_TOP)) starve_d = starve_q + 1'b1;
            end else if (grant_f) begin
               state_d   = BUSY_F;
               m_we_d    = 1'b0;
               m_addr_d  = f_addr;
               m_be_d    = '1;
               starve_d  = '0;
               discard_d = f_flush;
            end
         end
         BUSY_F: begin
            if (m_ack) begin
               state_d   = IDLE;
               discard_d = 1'b0;
            end else if (f_flush) begin
               discard_d = 1'b1;
            end
         end
         BUSY_D: begin
            if (m_ack) begin
               state_d   = IDLE;
               discard_d = 1'b0;
            end
         end
         default: begin
            state_d   = IDLE;
            discard_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_be_q    <= '0;
         starve_q  <= '0;
         discard_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_be_q    <= m_be_d;
         starve_q  <= starve_d;
         discard_q <= discard_d;
      end
   end

   assign m_req   = (state_q == BUSY_F) || (state_q == BUSY_D);
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_be    = m_be_q;

   // A flush arriving together with the ack still kills the returning instruction.
   assign f_valid = (state_q == BUSY_F) && m_ack && !discard_q && !f_flush;
   assign d_valid = (state_q == BUSY_D) && m_ack;
   assign f_rdata = m_rdata;
   assign d_rdata = m_rdata;
   assign f_stall = f_req && !f_valid;
   assign d_stall = d_req && !d_valid;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Bench for fetch_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model that also plays the memory.
module tb_fetch_mem_arbiter;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        f_req = 1'b0, f_flush = 1'b0;
   logic [31:0] f_addr = '0;
   logic [31:0] f_rdata;
   logic        f_valid, f_stall;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic [31:0] d_rdata;
   logic        d_valid, d_stall;
   logic        m_req, m_we;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   logic        m_ack = 1'b0;
   logic [31:0] m_rdata = '0;

   fetch_mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SM)) dut (
      .clk(clk), .reset_n(reset_n),
      .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
      .f_rdata(f_rdata), .f_valid(f_valid), .f_stall(f_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_ack(m_ack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: who owns the memory, the command it was given, fairness credit
   int          owner = 0;      // 0 none, 1 fetch, 2 data
   int          starve = 0;
   bit          disc = 1'b0;
   int          cnt = 0, lat = 1;
   logic        e_we = 1'b0;
   logic [31:0] e_addr = '0, e_wdata = '0;
   logic [3:0]  e_be = '0;
   int          glog[$];
   bit          f_done = 1'b0, d_done = 1'b0;
   int          n_done = 0;

   // stimulus knobs
   bit          auto_mode = 1'b0;
   int          lat_fixed = 1;
   bit          rd_fix_en = 1'b0;
   logic [31:0] rd_fix = '0;
   bit          man_flush = 1'b0;
   logic [31:0] man_faddr = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner = 0; starve = 0; disc = 1'b0; cnt = 0;
      f_done = 1'b0; d_done = 1'b0; m_ack = 1'b0;
   endtask

   task automatic model_edge();
      if (owner == 0) begin
         if (d_req && !(f_req && starve == SM)) begin
            owner = 2; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_be;
            if (f_req && starve < SM) starve++;
            glog.push_back(2);
         end else if (f_req) begin
            owner = 1; e_we = 1'b0; e_addr = f_addr; e_be = 4'hF;
            starve = 0; disc = f_flush;
            glog.push_back(1);
         end
         cnt = 0;
         lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
      end else if (m_ack) begin
         owner = 0; disc = 1'b0;
      end else if (owner == 1 && f_flush) begin
         disc = 1'b1;
      end
   endtask

   task automatic drive();
      if (owner != 0) begin
         cnt++;
         m_ack = (cnt == lat);
      end else begin
         m_ack = 1'b0;
      end
      m_rdata = rd_fix_en ? rd_fix : $urandom;
      if (auto_mode) begin
         f_flush = 1'b0;
         if (f_done) f_req = 1'b0;
         else if (!f_req && ($urandom % 100) < 50) begin
            f_req = 1'b1; f_addr = $urandom & 32'hFFFF_FFFC;
         end else if (f_req && ($urandom % 100) < 10) begin
            f_flush = 1'b1; f_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (d_done) d_req = 1'b0;
         else if (!d_req && ($urandom % 100) < 40) begin
            d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom;
            d_wdata = $urandom; d_be = 4'($urandom);
         end
      end else begin
         f_flush = man_flush;
         if (man_flush) f_addr = man_faddr;
         man_flush = 1'b0;
      end
   endtask

   task automatic check_outputs();
      bit fv, dv;
      fv = (owner == 1) && m_ack && !disc && !f_flush;
      dv = (owner == 2) && m_ack;
      check("m_req",   64'(m_req),   64'(owner != 0));
      check("f_valid", 64'(f_valid), 64'(fv));
      check("d_valid", 64'(d_valid), 64'(dv));
      check("f_stall", 64'(f_stall), 64'(f_req && !fv));
      check("d_stall", 64'(d_stall), 64'(d_req && !dv));
      if (owner != 0) begin
         check("m_we",   64'(m_we),   64'(e_we));
         check("m_addr", 64'(m_addr), 64'(e_addr));
         check("m_be",   64'(m_be),   64'(e_be));
         if (owner == 2) check("m_wdata", 64'(m_wdata), 64'(e_wdata));
      end
      if (fv) check("f_rdata", 64'(f_rdata), 64'(m_rdata));
      if (dv) check("d_rdata", 64'(d_rdata), 64'(m_rdata));
      f_done = fv;
      d_done = dv;
      if (fv || dv) n_done++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      drive();
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      int nfv, ndv, vcyc, cyc;

      // reset values, and stalls following inputs while reset is held
      repeat (2) @(negedge clk);
      check("rst_m_req",   64'(m_req),   64'd0);
      check("rst_m_we",    64'(m_we),    64'd0);
      check("rst_m_addr",  64'(m_addr),  64'd0);
      check("rst_m_wdata", 64'(m_wdata), 64'd0);
      check("rst_m_be",    64'(m_be),    64'd0);
      check("rst_f_valid", 64'(f_valid), 64'd0);
      check("rst_d_valid", 64'(d_valid), 64'd0);
      f_req = 1'b1; d_req = 1'b1; #1;
      check("rst_f_stall", 64'(f_stall), 64'd1);
      check("rst_d_stall", 64'(d_stall), 64'd1);
      f_req = 1'b0; d_req = 1'b0;
      reset_n = 1'b1;

      // fetch only, latency 1
      lat_fixed = 1; rd_fix_en = 1'b1; rd_fix = 32'hDEADBEEF;
      f_req = 1'b1; f_addr = 32'h100; #1;
      check("t1_c0_stall", 64'(f_stall), 64'd1);
      check("t1_c0_mreq",  64'(m_req),   64'd0);
      step();
      check("t1_c1_mreq",   64'(m_req),   64'd1);
      check("t1_c1_valid",  64'(f_valid), 64'd1);
      check("t1_c1_rdata",  64'(f_rdata), 64'hDEADBEEF);
      check("t1_c1_stall",  64'(f_stall), 64'd0);
      check("t1_c1_addr",   64'(m_addr),  64'h100);
      f_req = 1'b0;
      step();
      check("t1_c2_mreq", 64'(m_req), 64'd0);
      rd_fix_en = 1'b0;

      // both requesters held: starvation bound gives D,D,D,D,F,...
      glog.delete();
      f_req = 1'b1; f_addr = 32'h500;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
      repeat (20) step();
      f_req = 1'b0; d_req = 1'b0;
      check("t2_ngrants", 64'(glog.size()), 64'd10);
      for (int i = 0; i < 10 && i < glog.size(); i++)
         check("t2_order", 64'(glog[i]), 64'((i % 5 == 4) ? 1 : 2));
      repeat (2) step();

      // store with latency 3
      lat_fixed = 3; ndv = 0;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_be = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3_we",   64'(m_we),   64'd1);
         check("t3_be",   64'(m_be),   64'h3);
         check("t3_addr", 64'(m_addr), 64'h2000);
         if (d_done) ndv++;
      end
      check("t3_dvalid", 64'(d_valid), 64'd1);
      check("t3_dstall", 64'(d_stall), 64'd0);
      d_req = 1'b0;
      step();
      check("t3_pulses", 64'(ndv), 64'd1);
      check("t3_idle",   64'(m_req), 64'd0);

      // flush in cycle 2 of a latency-4 fetch, redirect to 0x400
      lat_fixed = 4; d_we = 1'b0;
      f_req = 1'b1; f_addr = 32'h200;
      step();
      man_flush = 1'b1; man_faddr = 32'h400;
      step();
      nfv = 0; vcyc = -1; cyc = 2;
      for (int i = 0; i < 15; i++) begin
         step();
         cyc++;
         if (f_done) begin
            nfv++;
            if (vcyc < 0) vcyc = cyc;
            check("t4_addr", 64'(m_addr), 64'h400);
            f_req = 1'b0;
         end
      end
      check("t4_nvalid", 64'(nfv), 64'd1);
      check("t4_vcycle", 64'(vcyc), 64'd9);

      // flush coinciding with the ack
      lat_fixed = 2;
      f_req = 1'b1; f_addr = 32'h600;
      step();
      man_flush = 1'b1; man_faddr = 32'h700;
      step();
      check("t5_ack_valid", 64'(f_valid), 64'd0);
      step();
      check("t5_idle", 64'(m_req), 64'd0);
      f_req = 1'b0;
      repeat (2) step();

      // reset during a data transaction
      lat_fixed = 4;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; d_be = 4'hF;
      step();
      check("t6_busy", 64'(m_req), 64'd1);
      reset_n = 1'b0; #1;
      check("t6_rst_mreq",  64'(m_req),   64'd0);
      check("t6_rst_addr",  64'(m_addr),  64'd0);
      check("t6_rst_dstall", 64'(d_stall), 64'd1);
      model_reset();
      @(posedge clk); #1;
      check("t6_held_mreq", 64'(m_req), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      check("t6_regrant",   64'(m_req),  64'd1);
      check("t6_regr_addr", 64'(m_addr), 64'h800);
      ndv = 0;
      for (int i = 0; i < 8 && ndv == 0; i++) begin
         step();
         if (d_done) ndv = 1;
      end
      check("t6_done", 64'(ndv), 64'd1);
      d_req = 1'b0;
      repeat (2) step();

      // randomized traffic
      auto_mode = 1'b1; lat_fixed = 0; n_done = 0;
      repeat (3000) step();
      check("rand_progress", 64'(n_done > 100), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
